// File: rtl/switches_ctrl_pkg.sv
// Shared constants for the slide-switch debounce / interrupt controller:
// Avalon register addresses, edge-mode encodings, CONTROL layout and the
// per-bit debounce FSM state encodings.
package switches_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam logic [1:0] MODE_ANY  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  localparam int         CTRL_DEB_EN = 2;
  localparam logic [2:0] CTRL_RESET  = 3'b100;

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_COUNT  = 1'b1;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch input: 2-flop synchronizer followed by a STABLE/COUNT debounce
// FSM. A new level is accepted only after it has been seen continuously for
// DEBOUNCE_CYCLES cycles.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   raw           - asynchronous switch level
//   enable        - debounce enable; when low the level follows the synchronizer
//   prime         - power-up priming; level follows the synchronizer, counter held
//   level         - registered debounced level
//   level_next    - value level takes at the next clock edge (for edge detect)
module switch_debounce_bit
  import switches_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic enable,
  input  logic prime,
  output logic level,
  output logic level_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Stage p0 -> p1: two-flop synchronizer on the raw pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    level_next = level;
    state_next = state;
    cnt_next   = cnt;
    if (prime || !enable) begin
      // Track the synchronizer directly; any count in progress is discarded.
      level_next = sync_p1;
      state_next = ST_STABLE;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_STABLE: begin
          if (sync_p1 != level) begin
            state_next = ST_COUNT;
            cnt_next   = CNT_W'(1);
          end
        end
        default: begin
          if (sync_p1 == level) begin
            state_next = ST_STABLE;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            level_next = sync_p1;
            state_next = ST_STABLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Stage p1 -> debounced level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

endmodule

// File: rtl/switches_debounce_irq_ctrl.sv
// Avalon-MM slave for the slide-switch port: debounced switch levels, sticky
// edge capture with write-1-to-clear, an interrupt mask and a level irq.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      - Avalon-MM slave write/select
//   in_port                 - raw asynchronous switch levels
//   readdata                - registered read data (1-cycle latency)
//   irq                     - |(edge_capture & irq_mask), active high
module switches_debounce_irq_ctrl
  import switches_ctrl_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [1:0]       prime_cnt;
  logic             prime;
  logic             wr_en;
  logic [2:0]       control;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:WIDTH];

  // Priming lasts three cycles after reset release, long enough for the
  // synchronizer to fill so switches already high at power-up load silently.
  assign prime = (prime_cnt != 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= 2'd0;
    end else if (prime) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (in_port[i]),
      .enable    (control[CTRL_DEB_EN]),
      .prime     (prime),
      .level     (debounced[i]),
      .level_next(debounced_next[i])
    );
  end

  always_comb begin
    rise = debounced_next & ~debounced;
    fall = ~debounced_next & debounced;
    case (control[1:0])
      MODE_ANY:  edge_set = rise | fall;
      MODE_RISE: edge_set = rise;
      MODE_FALL: edge_set = fall;
      MODE_NONE: edge_set = '0;
      default:   edge_set = '0;
    endcase
    if (prime) begin
      edge_set = '0;
    end
  end

  assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // Register file; a capture on the same edge as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      control      <= CTRL_RESET;
    end else begin
      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (wr_en && address == ADDR_CTRL) begin
        control <= writedata[2:0];
      end
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = {{(32-WIDTH){1'b0}}, debounced};
      ADDR_MASK: rd_mux = {{(32-WIDTH){1'b0}}, irq_mask};
      ADDR_EDGE: rd_mux = {{(32-WIDTH){1'b0}}, edge_capture};
      default:   rd_mux = {29'd0, control};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_switches_debounce_irq_ctrl.sv
module tb_switches_debounce_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp;
  int n_err;
  logic [31:0] rv;

  switches_debounce_irq_ctrl #(
    .WIDTH          (10),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    in_port    = 10'h3FF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    tick(); tick();
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    repeat (10) tick();

    // Power-up with all switches high: loaded without edges
    rd(2'd0, rv); check("prime_data", rv, 32'h3FF);
    rd(2'd2, rv); check("prime_edge", rv, 32'h0);
    check("prime_irq", {31'd0, irq}, 32'h0);
    rd(2'd3, rv); check("ctrl_reset", rv, 32'h4);
    rd(2'd1, rv); check("mask_reset", rv, 32'h0);

    // All switches fall, any-edge mode captures them
    in_port = 10'h000;
    repeat (10) tick();
    rd(2'd0, rv); check("fall_data", rv, 32'h0);
    rd(2'd2, rv); check("fall_capture", rv, 32'h3FF);
    wr(2'd2, 32'h3FF);
    rd(2'd2, rv); check("w1c_all", rv, 32'h0);

    wr(2'd1, 32'h001);
    rd(2'd1, rv); check("mask_rw", rv, 32'h001);

    // bit0 step: debounced changes 6 edges after the step
    address = 2'd0;
    in_port = 10'h001;
    repeat (5) tick();
    check("step_irq_t5", {31'd0, irq}, 32'h0);
    tick();
    check("step_irq_t6", {31'd0, irq}, 32'h1);
    check("step_data_t6", readdata, 32'h0);
    tick();
    check("step_data_t7", readdata, 32'h1);
    rd(2'd2, rv); check("step_capture", rv, 32'h1);
    wr(2'd2, 32'h1);
    check("clear_irq", {31'd0, irq}, 32'h0);

    // bit3 glitch of 3 cycles is rejected
    in_port = 10'h009;
    repeat (3) tick();
    in_port = 10'h001;
    repeat (10) tick();
    rd(2'd0, rv); check("glitch_data", rv, 32'h001);
    rd(2'd2, rv); check("glitch_capture", rv, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'h0);

    // Rising-only mode on bit5
    in_port = 10'h021;
    repeat (10) tick();
    wr(2'd2, 32'h3FF);
    wr(2'd3, 32'h5);
    rd(2'd3, rv); check("ctrl_rw", rv, 32'h5);
    wr(2'd1, 32'h021);
    in_port = 10'h001;
    repeat (10) tick();
    rd(2'd2, rv); check("rise_fall_ignored", rv, 32'h0);
    check("rise_fall_irq", {31'd0, irq}, 32'h0);
    in_port = 10'h021;
    repeat (10) tick();
    rd(2'd2, rv); check("rise_capture", rv, 32'h020);
    check("rise_irq", {31'd0, irq}, 32'h1);
    wr(2'd2, 32'h020);
    check("w1c_irq_drop", {31'd0, irq}, 32'h0);
    rd(2'd2, rv); check("w1c_read", rv, 32'h0);

    // Clear of bit0 on the very edge a new bit0 rise is captured
    in_port = 10'h020;
    repeat (10) tick();
    in_port = 10'h021;
    repeat (5) tick();
    wr(2'd2, 32'h001);
    check("set_wins_irq", {31'd0, irq}, 32'h1);
    rd(2'd2, rv); check("set_wins_capture", rv, 32'h001);

    // Mask clear drops irq, capture retained
    wr(2'd1, 32'h0);
    check("mask_clear_irq", {31'd0, irq}, 32'h0);
    rd(2'd2, rv); check("mask_clear_retain", rv, 32'h001);

    // Debounce disabled: bit9 follows the synchronizer
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h200);
    address = 2'd0;
    in_port = 10'h221;
    repeat (4) tick();
    rd(2'd0, rv); check("deb_off_data", rv, 32'h221);
    check("deb_off_irq", {31'd0, irq}, 32'h1);

    // Re-enable, start a count, then reset asynchronously mid-cycle
    wr(2'd3, 32'h4);
    in_port = 10'h021;
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(2'd0, rv); check("post_rst_data", rv, 32'h021);
    rd(2'd1, rv); check("post_rst_mask", rv, 32'h0);
    rd(2'd2, rv); check("post_rst_edge", rv, 32'h0);
    rd(2'd3, rv); check("post_rst_ctrl", rv, 32'h4);
    check("post_rst_irq", {31'd0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
